mult_div_unit: RTL and testbench

- Iterative multiply/divide unit directly downstream of the register file.
- Consumes the two register read operands (RD1 -> src_a, RD2 -> src_b) for MULT/MULTU/DIV/DIVU.
- Holds the 64-bit result in architectural HI/LO registers, which MFHI/MFLO read back for writeback to the register file.
- Multi-cycle: a start/busy/done handshake lets the control unit stall while an operation is in flight.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_negate.sv | 12 +
 rtl/mult_div_unit.sv | 174 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and defaults for the multiply/divide unit
package mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - conditional two's-complement negation of an N-bit value
module mdu_negate #(
    parameter int N = 32
) (
    input  logic         en,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    assign dout = en ? (~din + N'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
import mdu_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div_q;
    logic               neg_res;
    logic               neg_rem;
    logic               dbz_pend;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               b_zero;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_sh;
    logic               div_fits;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_step;

    logic [2*WIDTH-1:0] res_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign sign_a    = op_is_signed(op) & src_a[WIDTH-1];
    assign sign_b    = op_is_signed(op) & src_b[WIDTH-1];
    assign b_zero    = (src_b == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    mdu_negate #(.N(WIDTH)) u_abs_a (
        .en   (sign_a),
        .din  (src_a),
        .dout (abs_a)
    );

    mdu_negate #(.N(WIDTH)) u_abs_b (
        .en   (sign_b),
        .din  (src_b),
        .dout (abs_b)
    );

    // Low half of the 2*WIDTH negation doubles as the negated quotient.
    mdu_negate #(.N(2*WIDTH)) u_fix_res (
        .en   (neg_res),
        .din  (acc),
        .dout (res_fix)
    );

    mdu_negate #(.N(WIDTH)) u_fix_rem (
        .en   (neg_rem),
        .din  (acc[2*WIDTH-1:WIDTH]),
        .dout (rem_fix)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    assign mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                             : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}.
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign div_fits = (rem_sh >= {1'b0, opb});
    assign div_diff = rem_sh[WIDTH-1:0] - opb;
    assign div_step = div_fits ? {div_diff, acc[WIDTH-2:0], 1'b1}
                               : {acc[2*WIDTH-2:0], 1'b0};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_is_div(op) && b_zero) state_nxt = FIX;
                    else if (op_is_div(op))      state_nxt = DIV;
                    else                         state_nxt = MUL;
                end
            end
            MUL, DIV: begin
                if (last_iter) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dbz_pend <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (hilo_we) begin
                        if (hilo_sel) hi_q <= hilo_wd;
                        else          lo_q <= hilo_wd;
                    end
                    if (start) begin
                        cnt      <= '0;
                        is_div_q <= op_is_div(op);
                        neg_res  <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        dbz_pend <= op_is_div(op) & b_zero;
                        acc      <= {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
                        opb      <= op_is_div(op) ? abs_b : abs_a;
                    end
                end
                MUL: begin
                    acc <= mul_step;
                    cnt <= cnt + CNT_W'(1);
                end
                DIV: begin
                    acc <= div_step;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (dbz_pend) begin
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= is_div_q ? rem_fix : res_fix[2*WIDTH-1:WIDTH];
                        lo_q <= res_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state == MUL) || (state == DIV);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        hilo_we = 1'b0;
    logic        hilo_sel = 1'b0;
    logic [31:0] hilo_wd = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int edges;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hilo_we     (hilo_we),
        .hilo_sel    (hilo_sel),
        .hilo_wd     (hilo_wd),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        src_a = 32'hA5A5_A5A5;
        src_b = 32'h5A5A_5A5A;
        op    = ~o;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (done) break;
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        tick();
        tick();
        reset = 1'b1;

        // MULTU 0xFFFFFFFF * 0xFFFFFFFF with per-cycle busy check
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            check("multu_busy", {62'd0, busy, done}, 64'd2);
            tick();
        end
        check("multu_fix_cycle", {62'd0, busy, done}, 64'd0);
        tick();
        check("multu_done", {62'd0, busy, done}, 64'd1);
        check("multu_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        tick();
        check("multu_done_pulse", {63'd0, done}, 64'd0);

        // MULT -3 * 7
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(edges);
        check("mult_latency", 64'(edges), 64'd33);
        check("mult_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // DIV -7 / 2
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges);
        check("div_latency", 64'(edges), 64'd33);
        check("div_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIVU 0xFFFFFFFF / 0x10
        start_op(2'b11, 32'hFFFF_FFFF, 32'h10);
        wait_done(edges);
        check("divu_result", {hi, lo}, 64'h0000_000F_0FFF_FFFF);

        // DIV overflow wraps
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges);
        check("div_ovf_result", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_no_dbz", {63'd0, div_by_zero}, 64'd0);
        tick();

        // MTHI / MTLO then divide by zero
        hilo_we  = 1'b1;
        hilo_sel = 1'b1;
        hilo_wd  = 32'h1234;
        tick();
        hilo_sel = 1'b0;
        hilo_wd  = 32'h5678;
        tick();
        hilo_we = 1'b0;
        check("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_5678);
        start_op(2'b11, 32'd99, 32'd0);
        check("dbz_e0_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        tick();
        check("dbz_e1_flags", {61'd0, busy, done, div_by_zero}, 64'd3);
        check("dbz_hilo_kept", {hi, lo}, 64'h0000_1234_0000_5678);
        tick();
        check("dbz_pulse_end", {62'd0, done, div_by_zero}, 64'd0);

        // MULTU 5*6 with ignored start and ignored hilo_we while busy
        start_op(2'b01, 32'd5, 32'd6);
        repeat (4) tick();
        op    = 2'b11;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        hilo_we  = 1'b1;
        hilo_sel = 1'b0;
        hilo_wd  = 32'hDEAD_BEEF;
        tick();
        hilo_we = 1'b0;
        wait_done(edges);
        check("busy_ignore_latency", 64'(edges + 11), 64'd33);
        check("busy_ignore_result", {hi, lo}, 64'd30);
        tick();
        check("no_queued_op", {62'd0, busy, done}, 64'd0);

        // asynchronous reset mid-operation
        start_op(2'b11, 32'd100, 32'd7);
        repeat (12) tick();
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        tick();
        reset = 1'b1;
        start_op(2'b01, 32'd3, 32'd4);
        wait_done(edges);
        check("post_reset_latency", 64'(edges), 64'd33);
        check("post_reset_result", {hi, lo}, 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
